// File: rtl/thd_pingpong_buf.sv
// thd_pingpong_buf: two-bank frame buffer; one bank fills while the other
// is held for random-access reads.
// Ports: clk, rst_n (sync, active-low); write side wr_data/wr_valid/
// wr_ready/wr_frame_done; read side rd_frame_valid, rd_en/rd_addr ->
// rd_data/rd_data_valid, rd_done releases the held frame; frame_cnt.
module thd_pingpong_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int FRAME_LEN  = 2048,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_frame_done,
  output logic                  rd_frame_valid,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_done,
  output logic [15:0]           frame_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FL =
    (ADDR_WIDTH + 1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY,
    HOLD,
    FULL
  } state_t;

  state_t                state;
  logic                  wb;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  logic accept;
  logic frame_done;
  logic rd_take;
  logic in_range;

  assign accept     = rst_n & wr_valid & wr_ready;
  assign frame_done = accept & (wr_ptr == LAST);
  assign rd_take    = rd_en & rd_frame_valid;
  assign in_range   = {1'b0, rd_addr} < FL;

  assign wr_frame_done = frame_done;

  // RAM: the read bank is always the one opposite wb.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wb, wr_ptr}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= EMPTY;
      wb             <= 1'b0;
      wr_ptr         <= '0;
      frame_cnt      <= '0;
      wr_ready       <= 1'b0;
      rd_frame_valid <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= frame_done ? '0 : wr_ptr + 1'b1;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      unique case (state)
        EMPTY: begin
          wr_ready       <= 1'b1;
          rd_frame_valid <= frame_done;
          if (frame_done) begin
            state <= HOLD;
            wb    <= ~wb;
          end
        end
        HOLD: begin
          wr_ready       <= ~(frame_done & ~rd_done);
          rd_frame_valid <= ~(rd_done & ~frame_done);
          if (frame_done && rd_done) begin
            wb <= ~wb;
          end else if (frame_done) begin
            state <= FULL;
          end else if (rd_done) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          rd_frame_valid <= 1'b1;
          wr_ready       <= rd_done;
          if (rd_done) begin
            state <= HOLD;
            wb    <= ~wb;
          end
        end
        default: begin
          state          <= EMPTY;
          wr_ready       <= 1'b1;
          rd_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // Data only moves on a valid read, so rd_data holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_take;
      if (rd_take) begin
        s1_data <= in_range ? mem[{~wb, rd_addr}] : '0;
      end
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rd_data       = s2_data;
    assign rd_data_valid = s2_valid;
  end else begin : g_noreg
    assign rd_data       = s1_data;
    assign rd_data_valid = s1_valid;
  end

endmodule

// File: tb/tb_thd_pingpong_buf.sv
// tb_thd_pingpong_buf: two instances (8-sample/latency 1 and
// 4-sample/latency 2) driven alike, checked against a frame-queue model.
module tb_thd_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        rd_done;

  logic [1:0]  wr_ready;
  logic [1:0]  wr_frame_done;
  logic [1:0]  rd_frame_valid;
  logic [1:0]  rd_data_valid;
  logic [15:0] rd_data [2];
  logic [15:0] frame_cnt [2];

  always #5 clk = ~clk;

  thd_pingpong_buf #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3),
    .FRAME_LEN(8), .OUTPUT_REG(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready[0]),
    .wr_frame_done(wr_frame_done[0]),
    .rd_frame_valid(rd_frame_valid[0]),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[0]),
    .rd_data_valid(rd_data_valid[0]),
    .rd_done(rd_done),
    .frame_cnt(frame_cnt[0])
  );

  thd_pingpong_buf #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3),
    .FRAME_LEN(4), .OUTPUT_REG(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready[1]),
    .wr_frame_done(wr_frame_done[1]),
    .rd_frame_valid(rd_frame_valid[1]),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data[1]),
    .rd_data_valid(rd_data_valid[1]),
    .rd_done(rd_done),
    .frame_cnt(frame_cnt[1])
  );

  function automatic int fl(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  typedef struct {
    logic [15:0] d;
    int unsigned due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  logic [15:0] held [2][2][8];
  logic [15:0] cur [2][8];
  int          nheld [2];
  int          ptr [2];
  logic [15:0] fcnt [2];
  logic        ready [2];
  logic [15:0] lastd [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] cyc=%0d got=%h want=%h",
               nm, i, cyc, act, exp);
    end
  endtask

  // Reference model: frames are whole arrays; the reader owns the oldest.
  initial forever begin
    logic acc;
    logic cmp;
    exp_t e;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        nheld[i] = 0;
        ptr[i]   = 0;
        fcnt[i]  = 16'h0;
        ready[i] = 1'b0;
        lastd[i] = 16'h0;
        if (i == 0) q0.delete();
        else q1.delete();
      end else begin
        acc = wr_valid && ready[i];
        cmp = acc && (ptr[i] == fl(i) - 1);
        if (rd_en && nheld[i] > 0) begin
          e.d = (int'(rd_addr) < fl(i)) ?
                held[i][0][rd_addr] : 16'h0;
          e.due = cyc + lat(i) - 1;
          if (i == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        if (acc) begin
          cur[i][ptr[i]] = wr_data;
          ptr[i] = cmp ? 0 : ptr[i] + 1;
        end
        if (rd_done && nheld[i] > 0) begin
          held[i][0] = held[i][1];
          nheld[i]--;
        end
        if (cmp) begin
          held[i][nheld[i]] = cur[i];
          nheld[i]++;
          fcnt[i]++;
        end
        ready[i] = (nheld[i] < 2);
      end
    end
  end

  // Monitor: status every cycle, read data popped from the scoreboard.
  initial forever begin
    exp_t e;
    int   sz;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("wr_ready", i, 32'(wr_ready[i]), 32'(ready[i]));
      chk("rd_frame_valid", i, 32'(rd_frame_valid[i]),
          32'(nheld[i] > 0));
      chk("wr_frame_done", i, 32'(wr_frame_done[i]),
          32'(rst_n && wr_valid && ready[i] &&
              ptr[i] == fl(i) - 1));
      chk("frame_cnt", i, 32'(frame_cnt[i]), 32'(fcnt[i]));
      sz = (i == 0) ? q0.size() : q1.size();
      if (rd_data_valid[i]) begin
        if (sz == 0) begin
          chk("rd_unexpected", i, 32'(1), 32'(0));
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          lastd[i] = e.d;
          chk("rd_latency", i, cyc, e.due);
          chk("rd_data", i, 32'(rd_data[i]), 32'(e.d));
        end
      end else begin
        if (sz > 0) begin
          e = (i == 0) ? q0[0] : q1[0];
          if (e.due <= cyc) begin
            chk("rd_missing", i, cyc, e.due + 1);
          end
        end
        chk("rd_hold", i, 32'(rd_data[i]), 32'(lastd[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    rd_done  = 1'b0;
  endtask

  task automatic write_n(input int n, input logic [15:0] base,
                         input logic done_last);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wr_data  = base + 16'(k);
      rd_done  = done_last && (k == n - 1);
      step();
    end
    idle();
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      rd_en   = 1'b1;
      rd_addr = 3'(a);
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic release_frame();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_data = 16'h0;
    rd_addr = 3'd0;
    idle();
    repeat (3) step();
    rst_n = 1'b1;

    rd_en   = 1'b1;
    rd_addr = 3'd2;
    step();
    idle();
    step();

    write_n(8, 16'h0010, 1'b0);
    step();
    read_all();

    release_frame();
    write_n(20, 16'h0100, 1'b0);
    read_all();
    release_frame();
    step();
    read_all();

    write_n(8, 16'h0200, 1'b1);
    step();
    read_all();

    release_frame();
    release_frame();
    write_n(5, 16'h0300, 1'b0);
    rd_en   = 1'b1;
    rd_addr = 3'd1;
    rst_n   = 1'b0;
    step();
    idle();
    step();
    rst_n = 1'b1;
    write_n(8, 16'h0400, 1'b0);
    step();
    read_all();

    release_frame();
    step();
    force u0.frame_cnt = 16'hFFFF;
    fcnt[0] = 16'hFFFF;
    step();
    release u0.frame_cnt;
    step();
    write_n(8, 16'h0500, 1'b0);
    step();
    read_all();

    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 16'($urandom);
      rd_en    = ($urandom_range(0, 1) != 0);
      rd_addr  = 3'($urandom);
      rd_done  = ($urandom_range(0, 11) == 0);
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) step();

    chk("drain", 0, 32'(q0.size()), 32'(0));
    chk("drain", 1, 32'(q1.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
